// File: rtl/ascon_serial_host.sv
// Serial host for a bit-serial ASCON core. It loads operands MSB-first, strobes the core and waits
// for its ready flag, then captures the result stream LSB-first into parallel registers.
module ascon_serial_host #(
  parameter int K         = 128,
  parameter int A_L       = 112,
  parameter int TEXT_L    = 128,
  parameter int START_CYC = 3,
  parameter int GAP_CYC   = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [K-1:0]      key_in,
  input  logic [127:0]      nonce_in,
  input  logic [A_L-1:0]    ad_in,
  input  logic [TEXT_L-1:0] text_in,
  input  logic [127:0]      tag_in,
  output logic              key_SO,
  output logic              nonce_SO,
  output logic              associated_SO,
  output logic              plaintext_SO,
  output logic              tag_SO,
  output logic              encryption_s_SO,
  output logic              decryption_s_SO,
  input  logic              ciphertext_SI,
  input  logic              dec_plaintext_SI,
  input  logic              tag_SI,
  input  logic              dectag_SI,
  input  logic              encryption_r_SI,
  input  logic              decryption_r_SI,
  input  logic              msg_auth_SI,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [TEXT_L-1:0] text_out,
  output logic [127:0]      tag_out,
  output logic              auth_out
);

  localparam int MAX_KA  = (K > A_L) ? K : A_L;
  localparam int MAX_KAT = (MAX_KA > TEXT_L) ? MAX_KA : TEXT_L;
  localparam int MAX     = (MAX_KAT > 128) ? MAX_KAT : 128;
  localparam int BW      = $clog2(MAX + 1);
  localparam int TW      = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT, GAP, CAPTURE, DONE} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                mode_q, mode_d;
  logic [K-1:0]        key_q, key_d;
  logic [127:0]        nonce_q, nonce_d;
  logic [A_L-1:0]      ad_q, ad_d;
  logic [TEXT_L-1:0]   ptxt_q, ptxt_d;
  logic [127:0]        tagin_q, tagin_d;
  logic [TEXT_L-1:0]   text_q, text_d;
  logic [127:0]        tag_q, tag_d;
  logic                auth_q, auth_d;
  logic                terr_q, terr_d;

  logic rdy, txt_bit, tag_bit;

  // Only the ready/result lines of the requested direction are ever looked at.
  assign rdy     = mode_q ? decryption_r_SI : encryption_r_SI;
  assign txt_bit = mode_q ? dec_plaintext_SI : ciphertext_SI;
  assign tag_bit = mode_q ? dectag_SI : tag_SI;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      mode_q  <= 1'b0;
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      ptxt_q  <= '0;
      tagin_q <= '0;
      text_q  <= '0;
      tag_q   <= '0;
      auth_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      nonce_q <= nonce_d;
      ad_q    <= ad_d;
      ptxt_q  <= ptxt_d;
      tagin_q <= tagin_d;
      text_q  <= text_d;
      tag_q   <= tag_d;
      auth_q  <= auth_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tmr_d           = tmr_q;
    mode_d          = mode_q;
    key_d           = key_q;
    nonce_d         = nonce_q;
    ad_d            = ad_q;
    ptxt_d          = ptxt_q;
    tagin_d         = tagin_q;
    text_d          = text_q;
    tag_d           = tag_q;
    auth_d          = auth_q;
    terr_d          = terr_q;
    key_SO          = 1'b0;
    nonce_SO        = 1'b0;
    associated_SO   = 1'b0;
    plaintext_SO    = 1'b0;
    tag_SO          = 1'b0;
    encryption_s_SO = 1'b0;
    decryption_s_SO = 1'b0;
    busy            = (state_q != IDLE) && (state_q != DONE);
    done            = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          key_d   = key_in;
          nonce_d = nonce_in;
          ad_d    = ad_in;
          ptxt_d  = text_in;
          tagin_d = tag_in;
          terr_d  = 1'b0;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Streams shorter than MAX simply find no matching bit and stay at 0.
        for (int b = 0; b < K; b++)      if (cnt_q == BW'(b)) key_SO        = key_q[K-1-b];
        for (int b = 0; b < 128; b++)    if (cnt_q == BW'(b)) nonce_SO      = nonce_q[127-b];
        for (int b = 0; b < A_L; b++)    if (cnt_q == BW'(b)) associated_SO = ad_q[A_L-1-b];
        for (int b = 0; b < TEXT_L; b++) if (cnt_q == BW'(b)) plaintext_SO  = ptxt_q[TEXT_L-1-b];
        for (int b = 0; b < 128; b++)    if (cnt_q == BW'(b)) tag_SO        = tagin_q[127-b];
        if (cnt_q == BW'(MAX - 1)) begin
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STROBE: begin
        encryption_s_SO = ~mode_q;
        decryption_s_SO = mode_q;
        if (tmr_q == TW'(START_CYC - 1)) begin
          tmr_d   = '0;
          state_d = WAIT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      WAIT: begin
        if (rdy) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = (GAP_CYC == 0) ? CAPTURE : GAP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == TW'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = CAPTURE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      CAPTURE: begin
        for (int b = 0; b < TEXT_L; b++) if (cnt_q == BW'(b)) text_d[b] = txt_bit;
        for (int b = 0; b < 128; b++)    if (cnt_q == BW'(b)) tag_d[b]  = tag_bit;
        if (cnt_q == BW'(MAX - 1)) begin
          auth_d  = mode_q & msg_auth_SI;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign text_out    = text_q;
  assign tag_out     = tag_q;
  assign auth_out    = auth_q;
  assign timeout_err = terr_q;

endmodule
